// File: rtl/button_event.sv
// Turns a debounced active-low button level into press/release/long/repeat events.
// Auto-repeat in the LONG state is built only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250,
    parameter int CNT_W         = 16
) (
    input  logic m_clock,
    input  logic m_reset,
    input  logic m_level,
    output logic m_press,
    output logic m_release,
    output logic m_long,
    output logic m_repeat,
    output logic m_held
);

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        (HOLD_CYCLES - 1) >= (2 ** CNT_W) || (REPEAT_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_param
        $error("button_event: illegal HOLD_CYCLES/REPEAT_CYCLES/CNT_W combination");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    always_ff @(posedge m_clock) begin
        if (m_reset) begin
            state_q   <= ARM;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        unique case (state_q)
            // A button still held from reset must be seen released before it can press.
            ARM: begin
                cnt_d = '0;
                if (m_level) state_d = IDLE;
            end
            IDLE: begin
                cnt_d = '0;
                if (!m_level) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (m_level) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (m_level) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (cnt_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = ARM;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == PRESSED) || (state_d == LONG);
    end

    assign m_press   = press_q;
    assign m_release = release_q;
    assign m_long    = long_q;
    assign m_repeat  = repeat_q;
    assign m_held    = held_q;

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: an event-time model (elapsed cycles since press)
// is compared against the DUT after every edge, plus directed literal checks.
module tb_button_event;

    localparam int HOLD = 8;
    localparam int REP  = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic m_reset, m_level;
    logic m_press, m_release, m_long, m_repeat, m_held;

    button_event #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(16)) dut (
        .m_clock(clk), .m_reset(m_reset), .m_level(m_level),
        .m_press(m_press), .m_release(m_release), .m_long(m_long),
        .m_repeat(m_repeat), .m_held(m_held)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model state
    bit armed = 1'b0, pressed = 1'b0, chk_en = 1'b0;
    int press_edge = 0;
    logic e_press, e_release, e_long, e_repeat, e_held;

    // event log since last mark()
    int n_press, n_rel, n_long, n_rep;
    int first_press, last_rel, last_long, first_rep, last_rep;

    task automatic cmp(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic mark();
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
        first_press = -1; last_rel = -1; last_long = -1; first_rep = -1; last_rep = -1;
    endtask

    // Model + compare: events are derived from elapsed time since the press edge.
    initial begin
        logic lvl, rst;
        int el;
        mark();
        forever begin
            @(posedge clk);
            lvl = m_level;
            rst = m_reset;
            cyc++;
            #1;
            e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
            if (rst) begin
                armed = 0; pressed = 0; chk_en = 1;
            end else if (!armed) begin
                if (lvl) armed = 1;
            end else if (!pressed) begin
                if (!lvl) begin
                    pressed = 1; press_edge = cyc; e_press = 1;
                end
            end else if (lvl) begin
                pressed = 0; e_release = 1;
            end else begin
                el = cyc - press_edge;
                if (el == HOLD) e_long = 1;
                else if (REP_EN && el > HOLD && ((el - HOLD) % REP) == 0) e_repeat = 1;
            end
            e_held = pressed;

            if (e_press)   begin n_press++; if (first_press < 0) first_press = cyc; end
            if (e_release) begin n_rel++;  last_rel = cyc; end
            if (e_long)    begin n_long++; last_long = cyc; end
            if (e_repeat)  begin n_rep++;  last_rep = cyc; if (first_rep < 0) first_rep = cyc; end

            if (chk_en) begin
                cmp("press",   m_press,   e_press);
                cmp("release", m_release, e_release);
                cmp("long",    m_long,    e_long);
                cmp("repeat",  m_repeat,  e_repeat);
                cmp("held",    m_held,    e_held);
            end
        end
    end

    // Called at a negedge; the first edge to sample lv is cyc+1.
    task automatic hold(input logic lv, input int n);
        m_level = lv;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k, len;
        logic lv;
        m_reset = 1'b1;
        m_level = 1'b0;
        @(negedge clk);
        hold(1'b0, 2);
        cmp("rst_held", m_held, 1'b0);
        cmp("rst_press", m_press, 1'b0);
        m_reset = 1'b0;

        // Button held through reset: no events at all.
        mark();
        hold(1'b0, 20);
        hold(1'b1, 3);
        cmp_int("arm_no_press", n_press, 0);
        cmp_int("arm_no_rel", n_rel, 0);
        cmp("arm_held", m_held, 1'b0);

        // Short press of 3 cycles.
        mark();
        k = cyc + 1;
        hold(1'b0, 3);
        hold(1'b1, 4);
        cmp_int("short_press_at", first_press, k);
        cmp_int("short_rel_at", last_rel, k + 3);
        cmp_int("short_no_long", n_long, 0);

        // 20-cycle hold: long, repeats, release wins over the coincident repeat.
        mark();
        k = cyc + 1;
        hold(1'b0, 20);
        hold(1'b1, 4);
        cmp_int("hold_long_at", last_long, k + 8);
        cmp_int("hold_rep_cnt", n_rep, REP_EN ? 2 : 0);
        cmp_int("hold_rep_first", first_rep, REP_EN ? k + 12 : -1);
        cmp_int("hold_rep_last", last_rep, REP_EN ? k + 16 : -1);
        cmp_int("hold_rel_at", last_rel, k + 20);

        // Release exactly on the long threshold.
        mark();
        k = cyc + 1;
        hold(1'b0, 8);
        hold(1'b1, 3);
        cmp_int("thr_no_long", n_long, 0);
        cmp_int("thr_rel_at", last_rel, k + 8);

        // Reset in LONG: outputs clear, no release, ARM needs a high sample first.
        mark();
        hold(1'b0, 12);
        m_reset = 1'b1;
        hold(1'b0, 1);
        cmp("rstlong_held", m_held, 1'b0);
        cmp("rstlong_rel", m_release, 1'b0);
        m_reset = 1'b0;
        hold(1'b0, 5);
        cmp_int("rstlong_no_rel", n_rel, 0);
        cmp_int("rstlong_press1", n_press, 1);
        hold(1'b1, 2);
        hold(1'b0, 3);
        cmp_int("rstlong_press2", n_press, 2);
        hold(1'b1, 2);

        // Randomized runs with occasional resets and threshold-biased lengths.
        lv = 1'b1;
        for (int i = 0; i < 200; i++) begin
            lv = ~lv;
            case ($urandom_range(0, 3))
                0:       len = HOLD;
                1:       len = HOLD + REP * $urandom_range(0, 3);
                default: len = $urandom_range(1, 24);
            endcase
            if ($urandom_range(0, 29) == 0) begin
                m_reset = 1'b1;
                hold(lv, 1);
                m_reset = 1'b0;
            end
            hold(lv, len);
        end
        hold(1'b1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumer end of the debounced-button path. Takes the clean, active-low level from the debouncer and turns it into single-cycle events for the game logic: press, release, long-press and auto-repeat.
- Sits between each debouncer instance and the game control FSM, one instance per button.
- All outputs are registered pulses or levels in the m_clock domain.

Parameters:
- HOLD_CYCLES, 1000, cycles the button must stay pressed after the press event before m_long fires; must be at least 2.
- REPEAT_CYCLES, 250, period of m_repeat pulses once in long-press; must be at least 2.
- CNT_W, 16, counter width; 2^CNT_W must exceed max(HOLD_CYCLES, REPEAT_CYCLES)-1.

Ports:
- m_clock  in  1  system clock, all logic on posedge.
- m_reset  in  1  synchronous, active-high reset.
- m_level  in  1  debounced button level; 0 = pressed, 1 = released. Already synchronous to m_clock.
- m_press  out  1  one-cycle pulse on press.
- m_release  out  1  one-cycle pulse on release.
- m_long  out  1  one-cycle pulse when the hold reaches HOLD_CYCLES.
- m_repeat  out  1  one-cycle pulse every REPEAT_CYCLES while in long-press.
- m_held  out  1  level; 1 while the FSM is in PRESSED or LONG.

Behaviour:
- Reset (m_reset=1 at a posedge):
  - state <= ARM, counter <= 0.
  - m_press, m_release, m_long, m_repeat, m_held all <= 0.
  - Reset overrides every other event, including mid-hold; no release pulse is generated.
- States: ARM, IDLE, PRESSED, LONG. All transitions and outputs update on the same posedge at which m_level is sampled (1-cycle latency from input to output).
- ARM:
  - Waits for m_level=1, then goes to IDLE.
  - No events are generated in ARM, so a button held through reset never produces m_press.
- IDLE, m_level=0 sampled:
  - state <= PRESSED, m_press <= 1, counter <= 0, m_held <= 1.
- PRESSED:
  - If m_level=1: state <= IDLE, m_release <= 1, counter <= 0, m_held <= 0.
  - Else if counter == HOLD_CYCLES-1: state <= LONG, m_long <= 1, counter <= 0.
  - Else: counter <= counter+1.
- LONG:
  - If m_level=1: same release action as PRESSED.
  - Else if counter == REPEAT_CYCLES-1: m_repeat <= 1, counter <= 0.
  - Else: counter <= counter+1.
- Pulse rules:
  - All pulse outputs default to 0 every cycle; each is high for exactly one cycle.
  - At most one pulse output is high in any cycle.
- Timing: press sampled at edge k gives
  - m_press at edge k;
  - m_long at edge k+HOLD_CYCLES;
  - m_repeat at edges k+HOLD_CYCLES+n*REPEAT_CYCLES, for n >= 1.
- Simultaneous events: release sampled in the same cycle as a counter threshold means release wins; no m_long or m_repeat is issued.
- A one-cycle low glitch on m_level in IDLE produces m_press at edge k and m_release at edge k+1. No minimum-width filtering is done; that is the debouncer's job.
- Counter never wraps: it is reset at each threshold or state change.

Optional Feature:
- BUTTON_EVENT_REPEAT_EN
- Defined: LONG state auto-repeat as described above.
- Undefined:
  - m_repeat is tied to 0.
  - The counter holds at 0 in LONG.
  - LONG leaves only on release or reset.
  - All other behaviour is unchanged.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4, BUTTON_EVENT_REPEAT_EN defined):
- Reset with m_level=0, deassert reset, hold m_level=0 for 20 cycles, then raise it -> no pulses at all; FSM in IDLE after the first m_level=1 sample.
- From IDLE, m_level=0 at edge 10, held 3 cycles, raised at edge 13 -> m_press at edge 10 only, m_held=1 for edges 10-12, m_release at edge 13, no m_long.
- From IDLE, m_level=0 from edge 10 through 29, raised at edge 30 -> m_press@10, m_long@18, m_repeat@22 and @26, m_release@30 (the @30 repeat is suppressed because release wins), m_held falls at 30.
- Release sampled exactly at edge k+8 (the long threshold) -> m_release only, no m_long.
- m_reset asserted at edge 20 during LONG -> all outputs 0 at 20, state ARM, no m_release; after reset, a press needs m_level=1 seen first.
- Rebuild without BUTTON_EVENT_REPEAT_EN, hold 30 cycles -> m_long@k+8, m_repeat never asserted, m_release on raise.
